hazard_control: RTL and testbench

Pipeline hazard and stall controller for the LC-3b five-stage pipeline. Sits beside the forwarding unit and directly upstream of it in the control path. Decides, per cycle, which pipeline registers load, flush or take a bubble, so that every hazard reaching the forwarding unit is resolvable by forwarding alone. Also handles load-use stalls, multi-cycle memory waits, the two-access LDI/STI sequence and taken-branch flushes, and keeps a stall-cycle counter.

---
 rtl/lc3b_types.sv | 59 +++++
 rtl/hazard_control_src_decode.sv | 34 +++
 rtl/hazard_control.sv | 137 +++++++++++++
 tb/tb_hazard_control.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: opcodes, register index, hazard FSM state and
// the bundle of pipeline-register controls the hazard unit drives.
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        IND_2ND  = 2'd2
    } lc3b_hazard_state;

    typedef struct packed {
        logic pc_load;
        logic if_id_load;
        logic id_ex_load;
        logic ex_mem_load;
        logic mem_wb_load;
        logic id_ex_bubble;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hazard_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam hazard_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam hazard_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hazard_ctrl_t CTRL_FETCH    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // LDI/STI need a second data access using the first one's result as address.
    function automatic logic is_indirect(input lc3b_opcode op);
        return (op == op_ldi) || (op == op_sti);
    endfunction

    function automatic logic is_load(input lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
    endfunction

endpackage

// File: rtl/hazard_control_src_decode.sv
// Which source register fields of the decode-stage instruction are actually
// read by the datapath (store-data register deliberately not included).
module hazard_src_decode
    import lc3b_types::*;
(
    input  lc3b_opcode opcode_i,
    input  logic       bit5_i,
    input  logic       bit11_i,
    output logic       sr1_used_o,
    output logic       sr2_used_o
);

    always_comb begin
        sr1_used_o = 1'b0;
        sr2_used_o = 1'b0;
        unique case (opcode_i)
            op_add, op_and: begin
                sr1_used_o = 1'b1;
                sr2_used_o = ~bit5_i;
            end
            op_not, op_shf,
            op_ldr, op_ldb, op_ldi,
            op_str, op_stb, op_sti,
            op_jmp: sr1_used_o = 1'b1;
            // JSRR reads the base register; JSR with PC offset reads nothing.
            op_jsr: sr1_used_o = ~bit11_i;
            default: begin
                sr1_used_o = 1'b0;
                sr2_used_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/hazard_control.sv
// Pipeline stall/flush controller: memory waits, LDI/STI second access,
// taken-branch flushes, load-use bubbles, fetch waits and a stall counter.
module hazard_control
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  lc3b_opcode       IF_ID_opcode,
    input  lc3b_reg          IF_ID_sr1,
    input  lc3b_reg          IF_ID_sr2,
    input  logic             IF_ID_bit5,
    input  logic             IF_ID_bit11,
    input  lc3b_opcode       ID_EX_opcode,
    input  lc3b_reg          ID_EX_dest,
    input  logic             ID_EX_reg_write,
    input  lc3b_opcode       EX_MEM_opcode,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic             dmem_resp,
    input  logic             imem_read,
    input  logic             imem_resp,
    input  logic             branch_taken,
    output logic             pc_load,
    output logic             IF_ID_load,
    output logic             ID_EX_load,
    output logic             EX_MEM_load,
    output logic             MEM_WB_load,
    output logic             ID_EX_bubble,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic             EX_MEM_flush,
    output logic             indirect_phase,
    output logic [CNT_W-1:0] stall_count
);

    lc3b_hazard_state state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    hazard_ctrl_t     ctrl;

    logic sr1_used, sr2_used;
    logic mem_access, mem_stall, load_use, fetch_wait;

    hazard_src_decode u_src_decode (
        .opcode_i   (IF_ID_opcode),
        .bit5_i     (IF_ID_bit5),
        .bit11_i    (IF_ID_bit11),
        .sr1_used_o (sr1_used),
        .sr2_used_o (sr2_used)
    );

    assign mem_access = dmem_read | dmem_write;
    assign fetch_wait = imem_read & ~imem_resp;

    assign load_use = is_load(ID_EX_opcode) && ID_EX_reg_write &&
                      ((sr1_used && (IF_ID_sr1 == ID_EX_dest)) ||
                       (sr2_used && (IF_ID_sr2 == ID_EX_dest)));

    // A response that completes the whole access releases the freeze in that
    // same cycle, so branch/load-use/fetch rules apply to the release cycle.
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_access && (!dmem_resp || is_indirect(EX_MEM_opcode))) begin
                    mem_stall = 1'b1;
                    state_d   = dmem_resp ? IND_2ND : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!dmem_resp) begin
                    mem_stall = 1'b1;
                end else if (is_indirect(EX_MEM_opcode)) begin
                    mem_stall = 1'b1;
                    state_d   = IND_2ND;
                end else begin
                    state_d = RUN;
                end
            end
            IND_2ND: begin
                if (!dmem_resp) begin
                    mem_stall = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        if (!reset_n) begin
            ctrl = CTRL_RUN;
        end else if (mem_stall) begin
            ctrl = CTRL_FREEZE;
        end else if (branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end else if (fetch_wait) begin
            ctrl = CTRL_FETCH;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!ctrl.pc_load && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= RUN;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign pc_load        = ctrl.pc_load;
    assign IF_ID_load     = ctrl.if_id_load;
    assign ID_EX_load     = ctrl.id_ex_load;
    assign EX_MEM_load    = ctrl.ex_mem_load;
    assign MEM_WB_load    = ctrl.mem_wb_load;
    assign ID_EX_bubble   = ctrl.id_ex_bubble;
    assign IF_ID_flush    = ctrl.if_id_flush;
    assign ID_EX_flush    = ctrl.id_ex_flush;
    assign EX_MEM_flush   = ctrl.ex_mem_flush;
    assign indirect_phase = reset_n && (state_q == IND_2ND);
    assign stall_count    = stall_count_q;

endmodule

// File: tb/tb_hazard_control.sv
// Directed bench for hazard_control: a transaction-level model of the stall
// rules is checked every cycle, plus hand-computed literal expectations.
module tb_hazard_control;
    import lc3b_types::*;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    lc3b_opcode IF_ID_opcode = op_br;
    lc3b_reg    IF_ID_sr1 = 3'd0, IF_ID_sr2 = 3'd0;
    logic       IF_ID_bit5 = 1'b0, IF_ID_bit11 = 1'b0;
    lc3b_opcode ID_EX_opcode = op_br;
    lc3b_reg    ID_EX_dest = 3'd0;
    logic       ID_EX_reg_write = 1'b0;
    lc3b_opcode EX_MEM_opcode = op_br;
    logic       dmem_read = 1'b0, dmem_write = 1'b0, dmem_resp = 1'b0;
    logic       imem_read = 1'b0, imem_resp = 1'b0, branch_taken = 1'b0;

    logic pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load;
    logic ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush, indirect_phase;
    logic [CNT_W-1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_opcode(IF_ID_opcode), .IF_ID_sr1(IF_ID_sr1), .IF_ID_sr2(IF_ID_sr2),
        .IF_ID_bit5(IF_ID_bit5), .IF_ID_bit11(IF_ID_bit11),
        .ID_EX_opcode(ID_EX_opcode), .ID_EX_dest(ID_EX_dest), .ID_EX_reg_write(ID_EX_reg_write),
        .EX_MEM_opcode(EX_MEM_opcode),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .imem_read(imem_read), .imem_resp(imem_resp), .branch_taken(branch_taken),
        .pc_load(pc_load), .IF_ID_load(IF_ID_load), .ID_EX_load(ID_EX_load),
        .EX_MEM_load(EX_MEM_load), .MEM_WB_load(MEM_WB_load),
        .ID_EX_bubble(ID_EX_bubble), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .EX_MEM_flush(EX_MEM_flush), .indirect_phase(indirect_phase),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // {pc, IF_ID, ID_EX, EX_MEM, MEM_WB loads, bubble, 3 flushes, indirect}
    logic [9:0] dut_vec;
    assign dut_vec = {pc_load, IF_ID_load, ID_EX_load, EX_MEM_load, MEM_WB_load,
                      ID_EX_bubble, IF_ID_flush, ID_EX_flush, EX_MEM_flush, indirect_phase};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_sr1(input lc3b_opcode op, input bit b11);
        case (op)
            op_add, op_and, op_not, op_shf, op_ldr, op_ldb, op_ldi,
            op_str, op_stb, op_sti, op_jmp: return 1'b1;
            op_jsr:  return !b11;
            default: return 1'b0;
        endcase
    endfunction

    // Model: a data transaction needs 1 response (2 for LDI/STI); the pipe is
    // frozen until the response that completes the transaction arrives.
    bit m_pending = 1'b0;
    int m_got = 0;
    int m_need = 0;
    int m_count = 0;

    task automatic model_cycle();
        logic [9:0] e;
        int need, got;
        bit active, freeze, ind, luse;
        if (!reset_n) begin
            m_pending = 1'b0;
            m_got = 0;
            m_count = 0;
            check("reset_outputs", 32'(dut_vec), 32'(10'b1111100000));
            check("reset_count", 32'(stall_count), 32'd0);
            return;
        end
        active = m_pending || dmem_read || dmem_write;
        need   = m_pending ? m_need : ((EX_MEM_opcode == op_ldi || EX_MEM_opcode == op_sti) ? 2 : 1);
        got    = m_pending ? m_got : 0;
        freeze = active && !(dmem_resp && (got + 1 == need));
        ind    = active && (got >= 1);
        luse   = (ID_EX_opcode == op_ldr || ID_EX_opcode == op_ldb || ID_EX_opcode == op_ldi)
                 && ID_EX_reg_write
                 && ((reads_sr1(IF_ID_opcode, IF_ID_bit11) && IF_ID_sr1 == ID_EX_dest) ||
                     ((IF_ID_opcode == op_add || IF_ID_opcode == op_and) && !IF_ID_bit5 &&
                      IF_ID_sr2 == ID_EX_dest));
        if (freeze)                        e = 10'b0000000000;
        else if (branch_taken)             e = 10'b1111101110;
        else if (luse)                     e = 10'b0011110000;
        else if (imem_read && !imem_resp)  e = 10'b0111101000;
        else                               e = 10'b1111100000;
        e[0] = ind;
        check("cycle_outputs", 32'(dut_vec), 32'(e));
        check("cycle_count", 32'(stall_count), 32'(m_count));
        if (!e[9] && m_count < CNT_MAX) m_count++;
        if (active) begin
            if (dmem_resp) got++;
            m_pending = (got < need);
            m_got = m_pending ? got : 0;
            m_need = need;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IF_ID_opcode = op_br; IF_ID_sr1 = 3'd0; IF_ID_sr2 = 3'd0; IF_ID_bit5 = 1'b0; IF_ID_bit11 = 1'b0;
        ID_EX_opcode = op_br; ID_EX_dest = 3'd0; ID_EX_reg_write = 1'b0;
        EX_MEM_opcode = op_br; dmem_read = 1'b0; dmem_write = 1'b0; dmem_resp = 1'b0;
        imem_read = 1'b0; imem_resp = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic load_in_ex(input lc3b_opcode op, input lc3b_reg dest);
        ID_EX_opcode = op; ID_EX_dest = dest; ID_EX_reg_write = 1'b1;
    endtask

    task automatic decode(input lc3b_opcode op, input lc3b_reg s1, input lc3b_reg s2,
                          input logic b5, input logic b11);
        IF_ID_opcode = op; IF_ID_sr1 = s1; IF_ID_sr2 = s2; IF_ID_bit5 = b5; IF_ID_bit11 = b11;
    endtask

    initial begin
        do_reset();
        #1;
        check("lit_reset_loads", 32'(dut_vec), 32'(10'b1111100000));
        check("lit_reset_count", 32'(stall_count), 32'd0);
        $display("txn reset: done");

        // Load-use via sr1: ldr R3 then add R1,R3,R2
        step();
        load_in_ex(op_ldr, 3'd3); decode(op_add, 3'd3, 3'd2, 1'b0, 1'b0);
        #1;
        check("lit_lu_pc_load", 32'(pc_load), 32'd0);
        check("lit_lu_bubble", 32'(ID_EX_bubble), 32'd1);
        step();
        idle_inputs(); decode(op_add, 3'd3, 3'd2, 1'b0, 1'b0);
        #1;
        check("lit_lu_after_vec", 32'(dut_vec), 32'(10'b1111100000));
        check("lit_lu_count", 32'(stall_count), 32'd1);
        $display("txn load_use sr1: count=%0d", stall_count);

        // No hazard: immediate add with sr2=R3, store data in R3, JSR offset
        step();
        load_in_ex(op_ldr, 3'd3); decode(op_add, 3'd1, 3'd3, 1'b1, 1'b0);
        #1;
        check("lit_imm_add_pc_load", 32'(pc_load), 32'd1);
        step();
        decode(op_str, 3'd1, 3'd3, 1'b0, 1'b0);
        #1;
        check("lit_str_data_pc_load", 32'(pc_load), 32'd1);
        step();
        decode(op_jsr, 3'd3, 3'd0, 1'b0, 1'b1);
        step();
        load_in_ex(op_ldb, 3'd5); decode(op_and, 3'd1, 3'd5, 1'b0, 1'b0);
        step();
        idle_inputs(); load_in_ex(op_ldi, 3'd6); decode(op_jmp, 3'd6, 3'd0, 1'b0, 1'b0);
        step();
        idle_inputs(); load_in_ex(op_ldr, 3'd4); decode(op_jsr, 3'd4, 3'd0, 1'b0, 1'b0);
        step();
        idle_inputs(); ID_EX_opcode = op_add; ID_EX_dest = 3'd2; ID_EX_reg_write = 1'b1;
        decode(op_add, 3'd2, 3'd2, 1'b0, 1'b0);
        step();
        idle_inputs();
        $display("txn load_use variants: count=%0d", stall_count);

        // Plain load with 3-cycle memory wait
        do_reset();
        EX_MEM_opcode = op_ldr; dmem_read = 1'b1; dmem_resp = 1'b0;
        #1;
        check("lit_memwait_freeze", 32'(dut_vec), 32'd0);
        step(); step();
        step();
        dmem_resp = 1'b1;
        #1;
        check("lit_memwait_release", 32'(dut_vec), 32'(10'b1111100000));
        step();
        idle_inputs();
        #1;
        check("lit_memwait_count", 32'(stall_count), 32'd3);
        $display("txn mem_wait: count=%0d", stall_count);

        // LDI: first response in cycle 2, second in cycle 4
        do_reset();
        EX_MEM_opcode = op_ldi; dmem_read = 1'b1; dmem_resp = 1'b0;
        step();
        dmem_resp = 1'b1;
        #1;
        check("lit_ldi_c2_ind", 32'(indirect_phase), 32'd0);
        step();
        dmem_resp = 1'b0;
        #1;
        check("lit_ldi_c3_ind", 32'(indirect_phase), 32'd1);
        check("lit_ldi_c3_pc", 32'(pc_load), 32'd0);
        step();
        dmem_resp = 1'b1;
        #1;
        check("lit_ldi_c4_vec", 32'(dut_vec), 32'(10'b1111100001));
        step();
        idle_inputs();
        #1;
        check("lit_ldi_count", 32'(stall_count), 32'd3);
        check("lit_ldi_done_ind", 32'(indirect_phase), 32'd0);
        $display("txn ldi: count=%0d", stall_count);

        // STI with immediate first response, then branch held during a stall
        EX_MEM_opcode = op_sti; dmem_write = 1'b1; dmem_resp = 1'b1;
        step(); step();
        idle_inputs(); EX_MEM_opcode = op_ldr; dmem_read = 1'b1; branch_taken = 1'b1;
        #1;
        check("lit_branch_in_stall", 32'(dut_vec), 32'd0);
        step();
        dmem_resp = 1'b1;
        step();
        idle_inputs();
        $display("txn sti + branch in stall: count=%0d", stall_count);

        // Branch beats load-use and fetch wait
        step();
        load_in_ex(op_ldr, 3'd3); decode(op_add, 3'd3, 3'd2, 1'b0, 1'b0);
        imem_read = 1'b1; imem_resp = 1'b0; branch_taken = 1'b1;
        #1;
        check("lit_branch_prio", 32'(dut_vec), 32'(10'b1111101110));
        step();
        idle_inputs(); imem_read = 1'b1; imem_resp = 1'b0;
        #1;
        check("lit_fetch_wait", 32'(dut_vec), 32'(10'b0111101000));
        step();
        idle_inputs();
        $display("txn branch priority: count=%0d", stall_count);

        // Asynchronous reset in the middle of an indirect sequence
        do_reset();
        EX_MEM_opcode = op_ldi; dmem_read = 1'b1; dmem_resp = 1'b1;
        step();
        dmem_resp = 1'b0;
        #1;
        check("lit_ind_before_reset", 32'(indirect_phase), 32'd1);
        reset_n = 1'b0;
        #1;
        check("lit_async_reset_vec", 32'(dut_vec), 32'(10'b1111100000));
        check("lit_async_reset_count", 32'(stall_count), 32'd0);
        step();
        idle_inputs();
        reset_n = 1'b1;
        step();
        $display("txn reset during IND_2ND: ind=%0d", indirect_phase);

        // Counter saturation under a long fetch wait
        do_reset();
        imem_read = 1'b1; imem_resp = 1'b0;
        for (int i = 0; i < 20; i++) step();
        idle_inputs();
        #1;
        check("lit_saturate", 32'(stall_count), 32'(CNT_MAX));
        step();
        $display("txn saturation: count=%0d", stall_count);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
